// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: grants a request,
// drives the ALU with a start pulse, waits LATENCY cycles and returns the result.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1   // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       mode0,
  input  logic [3:0]       mode1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [3:0]       alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result
);
  localparam int NUM_REQ = 2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0]            req_v, win, fin, gnt_v, done_v;
  logic [NUM_REQ-1:0][3:0]       mode_v;
  logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v;
  logic                          last_gnt, owner, win_idx, cnt_zero_q;
  logic [3:0]                    cnt;

  assign req_v   = {req1, req0};
  assign mode_v  = {mode1, mode0};
  assign a_v     = {a1, a0};
  assign b_v     = {b1, b0};
  assign win_idx = win[1];

  assign gnt0  = gnt_v[0];
  assign gnt1  = gnt_v[1];
  assign done0 = done_v[0];
  assign done1 = done_v[1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win       = '0;
    fin       = '0;
    case (state)
      IDLE: begin
        if (|req_v) begin
          // on a tie the requester not granted last time wins
          if (&req_v) win = last_gnt ? 2'b01 : 2'b10;
          else        win = req_v;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero_q) begin
          fin[owner] = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_v      <= '0;
      done_v     <= '0;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
      alu_mode   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      result     <= '0;
      cnt        <= '0;
      cnt_zero_q <= 1'b0;
      last_gnt   <= 1'b1;
      owner      <= 1'b0;
    end else begin
      gnt_v     <= win;
      done_v    <= fin;
      alu_start <= |win;
      if (|win) begin
        alu_mode <= mode_v[win_idx];
        alu_a    <= a_v[win_idx];
        alu_b    <= b_v[win_idx];
        last_gnt <= win_idx;
        owner    <= win_idx;
        cnt      <= CNT_LOAD;
        busy     <= 1'b1;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      // zero-detect is registered so the capture lands LATENCY cycles after start
      cnt_zero_q <= (state == WAIT) && (cnt == '0) && !cnt_zero_q;
      if (|fin) result <= alu_result;
      if (state == DONE) busy <= 1'b0;
    end
  end
endmodule
